vp_frame_writer: RTL and testbench
==================================

// Module: vp_frame_writer
// PURPOSE
//  Downstream of the video-processing stage: accepts Sobel-filtered grayscale pixels over a
//  ready/valid handshake and writes them into a double-buffered (ping-pong) frame buffer.
//  Generates linear write addresses, tracks row/column, and swaps banks with the display reader
//  at frame boundaries so the reader never sees a partially written frame.
// PARAMETERS
//  DW  12      pixel data width
//  RL  640     pixels per row
//  RN  480     rows per frame
//  AW  19      per-bank address width; must satisfy 2**AW >= RL*RN
// PORTS
//  i_clk             in   1     system clock
//  i_rst             in   1     synchronous reset, active-high
//  i_data_valid      in   1     upstream pixel valid
//  i_data            in   DW    upstream pixel
//  o_data_ready      out  1     ready to upstream; transfer = i_data_valid & o_data_ready
//  i_frame_sync      in   1     1-cycle pulse: next accepted pixel is (row 0, col 0)
//  i_rd_frame_done   in   1     1-cycle pulse from display reader: finished scanning o_rd_bank
//  o_mem_wr_en       out  1     frame-buffer write strobe
//  o_mem_addr        out  AW+1  {bank, linear pixel address}
//  o_mem_wr_data     out  DW    pixel to write
//  o_rd_bank         out  1     bank the reader must scan (always != write bank)
//  o_frame_done      out  1     1-cycle pulse when a frame has been written and its bank handed over
//  o_sync_err        out  1     1-cycle pulse: i_frame_sync arrived with counters not at (0,0)
// BEHAVIOUR
//  Reset: state=WRITE, wr_bank=0, o_rd_bank=1, col=row=addr=0, rd_done_flag=1;
//    o_mem_wr_en=0, o_mem_addr=0, o_mem_wr_data=0, o_frame_done=0, o_sync_err=0.
//  o_data_ready = (state==WRITE), decoded from the state register only; it never depends on
//    i_data_valid, which avoids combinational loops.
//  Accept: on a transfer, next cycle o_mem_wr_en=1, o_mem_addr={wr_bank,addr}, o_mem_wr_data=i_data
//    (latency 1, all memory outputs registered). No transfer -> o_mem_wr_en=0, addr/data held.
//  Counters: col 0..RL-1; at col==RL-1, col->0 and row++. addr increments by 1 per transfer.
//    No multiplier is used. Accepting (RN-1,RL-1) is the last pixel: counters -> 0, state->HOLD.
//  rd_done_flag: set by an i_rd_frame_done pulse in any state; cleared on a bank swap.
//  HOLD: o_data_ready=0. If rd_done_flag is set or i_rd_frame_done is high this cycle, swap:
//    wr_bank<=~wr_bank, o_rd_bank<=wr_bank (the frame just written), clear flag,
//    o_frame_done=1 for one cycle, ->WRITE. Otherwise stay in HOLD (back-pressure upstream).
//  First frame: rd_done_flag=1 from reset, so the swap happens on the cycle after entering HOLD.
//  i_frame_sync in WRITE: counters ->0 on that cycle. If counters were not already (0,0),
//    o_sync_err pulses; the partial frame is overwritten in the same bank with no swap.
//    If a transfer coincides with sync, that pixel is written to addr 0 and the counters
//    advance to col=1. i_frame_sync in HOLD is ignored; counters are already 0.
//  i_rst mid-frame: all state returns to reset values on the next edge. Any in-flight
//    o_mem_wr_en is dropped.
//  Bank invariant: o_rd_bank != wr_bank at every cycle.
// STRUCTURE
//  Shared header vp_defs.vh: RL, RN, AW defaults and the state encodings
//    (ST_WRITE=1'b0, ST_HOLD=1'b1), reused by the display reader.
//  One sub-module vp_pix_counter (col/row/addr counters, last-pixel flag, sync clear).
//    The top level holds the FSM, bank logic and output registers.
// TESTING  (RL=4, RN=2, AW=3 unless noted)
//  1 After reset, stream 8 pixels 0x001..0x008 with valid held high -> writes to addr 0..7 in
//    bank 0, one cycle after each accept. o_frame_done pulses once, o_rd_bank becomes 0, and
//    pixel 9 is written to {1,0}.
//  2 Second frame with no i_rd_frame_done -> o_data_ready=0 indefinitely after pixel 16.
//    Pulse i_rd_frame_done -> swap on that cycle, o_rd_bank=1, writes resume at {0,0}.
//  3 i_rd_frame_done pulsed mid-frame 2 -> the end-of-frame swap still occurs immediately
//    (flag is sticky), and o_frame_done pulses.
//  4 After 3 pixels, pulse i_frame_sync -> o_sync_err=1 once, the next pixel is written to
//    addr 0, same bank, and no o_frame_done.
//  5 Random valid gaps (~50%) over 3 frames -> exactly 8 writes per frame, addresses contiguous,
//    and no write while o_data_ready=0.
//  6 Assert i_rst at pixel 5 -> the next cycle matches the reset values and the restart writes
//    to {0,0}. Repeat with RL=640, RN=480 to check the final addr 307199.

Source files
------------

// File: rtl/vp_frame_writer_pkg.sv
// Shared definitions for the frame writer and the display reader: default geometry,
// FSM state encoding and a counter-width helper.
package vp_frame_writer_pkg;

    localparam int unsigned DefDw = 12;
    localparam int unsigned DefRl = 640;
    localparam int unsigned DefRn = 480;
    localparam int unsigned DefAw = 19;

    typedef enum logic {
        StWrite = 1'b0,
        StHold  = 1'b1
    } state_e;

    // Width of a counter that runs 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vp_frame_writer_pix_counter.sv
// Column/row/linear-address tracker for the frame writer. The address is a running count
// rather than row*RL+col, and a sync clear zeroes everything for the current cycle.
module vp_frame_writer_pix_counter
    import vp_frame_writer_pkg::*;
#(
    parameter int unsigned RL = DefRl,
    parameter int unsigned RN = DefRn,
    parameter int unsigned AW = DefAw
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_advance,
    input  logic          i_clear,
    output logic [AW-1:0] o_addr,
    output logic          o_last,
    output logic          o_at_origin
);

    localparam int unsigned CW = cnt_width(RL);
    localparam int unsigned RW = cnt_width(RN);

    logic [CW-1:0] col_q, col_d, col_base;
    logic [RW-1:0] row_q, row_d, row_base;
    logic [AW-1:0] addr_q, addr_d, addr_base;
    logic          col_is_last, row_is_last;

    always_comb begin
        // A clear applies to this cycle's pixel, so it lands at (0,0).
        col_base    = i_clear ? '0 : col_q;
        row_base    = i_clear ? '0 : row_q;
        addr_base   = i_clear ? '0 : addr_q;
        col_is_last = (col_base == CW'(RL - 1));
        row_is_last = (row_base == RW'(RN - 1));

        o_addr      = addr_base;
        o_last      = i_advance && col_is_last && row_is_last;
        o_at_origin = (col_q == '0) && (row_q == '0);

        col_d  = col_base;
        row_d  = row_base;
        addr_d = addr_base;
        if (i_advance) begin
            if (col_is_last) begin
                col_d = '0;
                if (row_is_last) begin
                    row_d  = '0;
                    addr_d = '0;
                end else begin
                    row_d  = row_base + RW'(1);
                    addr_d = addr_base + AW'(1);
                end
            end else begin
                col_d  = col_base + CW'(1);
                addr_d = addr_base + AW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/vp_frame_writer.sv
// Ping-pong frame-buffer writer: accepts pixels over ready/valid, writes them to the current
// bank and hands the finished bank to the display reader once it has released the other one.
module vp_frame_writer
    import vp_frame_writer_pkg::*;
#(
    parameter int unsigned DW = DefDw,
    parameter int unsigned RL = DefRl,
    parameter int unsigned RN = DefRn,
    parameter int unsigned AW = DefAw
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_data_valid,
    input  logic [DW-1:0] i_data,
    output logic          o_data_ready,
    input  logic          i_frame_sync,
    input  logic          i_rd_frame_done,
    output logic          o_mem_wr_en,
    output logic [AW:0]   o_mem_addr,
    output logic [DW-1:0] o_mem_wr_data,
    output logic          o_rd_bank,
    output logic          o_frame_done,
    output logic          o_sync_err
);

    state_e        state_q;
    logic          wr_bank_q;
    logic          rd_done_q;
    logic          transfer;
    logic          sync_clear;
    logic [AW-1:0] pix_addr;
    logic          pix_last;
    logic          at_origin;

    // Ready comes from the state register alone so upstream can safely depend on it.
    assign o_data_ready = (state_q == StWrite);
    assign transfer     = i_data_valid && o_data_ready;
    assign sync_clear   = i_frame_sync && o_data_ready;

    vp_frame_writer_pix_counter #(
        .RL (RL),
        .RN (RN),
        .AW (AW)
    ) u_pix_counter (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_advance   (transfer),
        .i_clear     (sync_clear),
        .o_addr      (pix_addr),
        .o_last      (pix_last),
        .o_at_origin (at_origin)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= StWrite;
            wr_bank_q     <= 1'b0;
            o_rd_bank     <= 1'b1;
            rd_done_q     <= 1'b1;
            o_mem_wr_en   <= 1'b0;
            o_mem_addr    <= '0;
            o_mem_wr_data <= '0;
            o_frame_done  <= 1'b0;
            o_sync_err    <= 1'b0;
        end else begin
            o_mem_wr_en  <= 1'b0;
            o_frame_done <= 1'b0;
            o_sync_err   <= 1'b0;
            // Sticky release from the reader; a swap below overrides it.
            if (i_rd_frame_done) begin
                rd_done_q <= 1'b1;
            end
            case (state_q)
                StWrite: begin
                    if (i_frame_sync && !at_origin) begin
                        o_sync_err <= 1'b1;
                    end
                    if (i_data_valid) begin
                        o_mem_wr_en   <= 1'b1;
                        o_mem_addr    <= {wr_bank_q, pix_addr};
                        o_mem_wr_data <= i_data;
                        if (pix_last) begin
                            state_q <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (rd_done_q || i_rd_frame_done) begin
                        wr_bank_q    <= ~wr_bank_q;
                        o_rd_bank    <= wr_bank_q;
                        rd_done_q    <= 1'b0;
                        o_frame_done <= 1'b1;
                        state_q      <= StWrite;
                    end
                end
                default: state_q <= StWrite;
            endcase
        end
    end

endmodule

// File: tb/tb_vp_frame_writer.sv
// Randomised scoreboard bench for vp_frame_writer: a small 4x2 instance against a linear-index
// reference model, plus a 20x15 instance streamed for one full frame.
module tb_vp_frame_writer;

    localparam int unsigned DW    = 12;
    localparam int unsigned RL    = 4;
    localparam int unsigned RN    = 2;
    localparam int unsigned AW    = 3;
    localparam int unsigned NPIX  = RL * RN;
    localparam int unsigned BRL   = 20;
    localparam int unsigned BRN   = 15;
    localparam int unsigned BAW   = 9;
    localparam int unsigned BNPIX = BRL * BRN;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          i_rst = 1'b1, i_data_valid = 1'b0, i_frame_sync = 1'b0, i_rd_frame_done = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          o_data_ready, o_mem_wr_en, o_rd_bank, o_frame_done, o_sync_err;
    logic [AW:0]   o_mem_addr;
    logic [DW-1:0] o_mem_wr_data;

    logic          b_rst = 1'b1, b_valid = 1'b0;
    logic [DW-1:0] b_data = '0;
    logic          b_ready, b_wr_en, b_rd_bank, b_fd, b_se;
    logic [BAW:0]  b_addr;
    logic [DW-1:0] b_wr_data;

    vp_frame_writer #(.DW(DW), .RL(RL), .RN(RN), .AW(AW)) dut (
        .i_clk           (clk),
        .i_rst           (i_rst),
        .i_data_valid    (i_data_valid),
        .i_data          (i_data),
        .o_data_ready    (o_data_ready),
        .i_frame_sync    (i_frame_sync),
        .i_rd_frame_done (i_rd_frame_done),
        .o_mem_wr_en     (o_mem_wr_en),
        .o_mem_addr      (o_mem_addr),
        .o_mem_wr_data   (o_mem_wr_data),
        .o_rd_bank       (o_rd_bank),
        .o_frame_done    (o_frame_done),
        .o_sync_err      (o_sync_err)
    );

    vp_frame_writer #(.DW(DW), .RL(BRL), .RN(BRN), .AW(BAW)) dut_big (
        .i_clk           (clk),
        .i_rst           (b_rst),
        .i_data_valid    (b_valid),
        .i_data          (b_data),
        .o_data_ready    (b_ready),
        .i_frame_sync    (1'b0),
        .i_rd_frame_done (1'b0),
        .o_mem_wr_en     (b_wr_en),
        .o_mem_addr      (b_addr),
        .o_mem_wr_data   (b_wr_data),
        .o_rd_bank       (b_rd_bank),
        .o_frame_done    (b_fd),
        .o_sync_err      (b_se)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: frame position is a single linear pixel index.
    bit          m_hold = 1'b0, m_bank = 1'b0, m_flag = 1'b1;
    int unsigned m_idx = 0;
    int unsigned pix = 1;
    logic [AW+DW:0] wr_q[$];

    bit e_wr = 1'b0, e_fd = 1'b0, e_se = 1'b0, e_rd_bank = 1'b1, e_ready = 1'b1, e_rst = 1'b0;
    bit mon_en = 1'b0;

    task automatic step(input bit v, input bit sync, input bit rdd, input bit rst);
        @(negedge clk);
        i_data_valid    = v;
        i_data          = DW'(pix);
        i_frame_sync    = sync;
        i_rd_frame_done = rdd;
        i_rst           = rst;
        e_wr = 1'b0;
        e_fd = 1'b0;
        e_se = 1'b0;
        e_rst = rst;
        if (rst) begin
            m_hold = 1'b0;
            m_idx  = 0;
            m_bank = 1'b0;
            m_flag = 1'b1;
        end else begin
            if (rdd) m_flag = 1'b1;
            if (!m_hold) begin
                if (sync) begin
                    if (m_idx != 0) e_se = 1'b1;
                    m_idx = 0;
                end
                if (v) begin
                    wr_q.push_back({m_bank, AW'(m_idx), DW'(pix)});
                    e_wr = 1'b1;
                    pix++;
                    if (m_idx == NPIX - 1) begin
                        m_idx  = 0;
                        m_hold = 1'b1;
                    end else begin
                        m_idx++;
                    end
                end
            end else if (m_flag) begin
                m_bank = ~m_bank;
                m_flag = 1'b0;
                e_fd   = 1'b1;
                m_hold = 1'b0;
            end
        end
        e_rd_bank = ~m_bank;
        e_ready   = ~m_hold;
        mon_en    = 1'b1;
    endtask

    // Monitor: compares what the DUT presents after each edge with the model's expectations.
    initial begin
        logic [AW+DW:0] exp_wr;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                chk("ready", 32'(o_data_ready), 32'(e_ready));
                chk("rd_bank", 32'(o_rd_bank), 32'(e_rd_bank));
                chk("frame_done", 32'(o_frame_done), 32'(e_fd));
                chk("sync_err", 32'(o_sync_err), 32'(e_se));
                chk("wr_en", 32'(o_mem_wr_en), 32'(e_wr));
                if (e_rst) begin
                    chk("rst_addr", 32'(o_mem_addr), 32'd0);
                    chk("rst_data", 32'(o_mem_wr_data), 32'd0);
                end
                if (o_mem_wr_en) begin
                    if (wr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wr_unexpected: write to 0x%0h with nothing expected",
                                 o_mem_addr);
                    end else begin
                        exp_wr = wr_q.pop_front();
                        chk("wr_addr", 32'(o_mem_addr), 32'(exp_wr[AW+DW -: AW+1]));
                        chk("wr_data", 32'(o_mem_wr_data), 32'(exp_wr[DW-1:0]));
                    end
                end else if (e_wr && wr_q.size() != 0) begin
                    void'(wr_q.pop_front());
                end
            end
        end
    end

    initial begin
        int unsigned n_sent, n_wr, fd_cnt, last_addr;
        bit acc;

        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Frame 1 into bank 0, immediate swap, then frame 2 with no reader release (stall).
        repeat (9) step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (8) step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);

        // Reader release mid-frame is remembered for the end-of-frame swap.
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);

        // Mid-frame sync restarts the frame in the same bank; sync with a transfer too.
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (10) step(1'b1, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 250; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 11) == 0), 1'b0);
        end

        // Reset mid-frame with a transfer on the same cycle, then restart.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        chk("wr_queue_empty", 32'(wr_q.size()), 32'd0);

        // Larger non-power-of-two frame streamed once.
        repeat (2) @(negedge clk);
        b_rst = 1'b0;
        n_sent = 0;
        n_wr = 0;
        fd_cnt = 0;
        last_addr = 0;
        acc = 1'b0;
        for (int i = 0; i < int'(BNPIX) + 10; i++) begin
            @(negedge clk);
            if (acc) n_sent++;
            b_valid = (n_sent < BNPIX);
            b_data  = DW'(n_sent);
            acc     = b_valid && b_ready;
            @(posedge clk);
            #1;
            if (b_wr_en) begin
                chk("big_addr", 32'(b_addr), 32'(n_wr));
                chk("big_data", 32'(b_wr_data), 32'(n_wr));
                last_addr = 32'(b_addr);
                n_wr++;
            end
            if (b_fd) fd_cnt++;
            if (b_se) chk("big_sync_err", 32'(b_se), 32'd0);
        end
        chk("big_writes", n_wr, BNPIX);
        chk("big_last_addr", last_addr, BNPIX - 1);
        chk("big_frame_done", fd_cnt, 32'd1);
        chk("big_rd_bank", 32'(b_rd_bank), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
